hazard_stall_unit: RTL and testbench

Producer-side companion to the pipeline forwarding logic in the 5-stage MIPS core. Forwarding covers every ALU result reachable from M or W. This block detects the cases forwarding cannot cover and generates stall and flush controls for F/D/E/M:
- load-use
- branch-compare-in-D dependence
- multi-cycle divide occupancy in E

It owns the only sequential state in hazard handling: the divide-busy FSM and an optional stall counter.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_stall_unit_div_busy_fsm.sv | 92 +++++++++
 rtl/hazard_stall_unit.sv | 110 +++++++++++
 tb/tb_hazard_stall_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard/stall unit.
// Holds the divide FSM state encoding, the default divide latency and the
// register-zero constant, plus a small compare helper used by the top level.
package hazard_pkg;

  // Divide occupancy FSM states; encodings are fixed for debug visibility.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Total cycles E is held by a divide, including the start cycle.
  localparam int unsigned DIV_LAT_DEFAULT = 32;

  // $zero never carries a dependence.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a writer's destination matches a reader's source and the
  // register is not $zero.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_div_busy_fsm.sv
// div_busy_fsm: tracks how long a multi-cycle divide occupies E.
// IDLE -> BUSY on divstart (cnt loaded with DIV_LAT-2), BUSY counts down to
// zero, then one DONE cycle in which the quotient/remainder become valid.
// The start cycle itself already stalls, so the hold totals DIV_LAT cycles.
module div_busy_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic divstart,
  output logic divstall,
  output logic divdone,
  output logic divbusy
);

  // Countdown preload: the IDLE start cycle and the final BUSY cycle at
  // cnt == 0 account for the two cycles not covered by the count.
  localparam logic [7:0] CNT_LOAD = 8'(DIV_LAT - 2);

  div_state_t state;
  logic [7:0] cnt;

  // State register and countdown; divstart is ignored outside IDLE since
  // the same divide is still sitting in E during BUSY and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (divstart) begin
            state <= DIV_BUSY;
            cnt   <= CNT_LOAD;
          end else begin
            state <= DIV_IDLE;
            cnt   <= cnt;
          end
        end
        DIV_BUSY: begin
          if (cnt != 8'd0) begin
            state <= DIV_BUSY;
            cnt   <= cnt - 8'd1;
          end else begin
            state <= DIV_DONE;
            cnt   <= cnt;
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
          cnt   <= cnt;
        end
        default: begin
          state <= DIV_IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Stall/done/busy are decoded combinationally so they act in the same cycle.
  always_comb begin
    divstall = 1'b0;
    divdone  = 1'b0;
    divbusy  = 1'b0;
    case (state)
      DIV_IDLE: begin
        divstall = divstart;
        divdone  = 1'b0;
        divbusy  = 1'b0;
      end
      DIV_BUSY: begin
        divstall = 1'b1;
        divdone  = 1'b0;
        divbusy  = 1'b1;
      end
      DIV_DONE: begin
        divstall = 1'b0;
        divdone  = 1'b1;
        divbusy  = 1'b1;
      end
      default: begin
        divstall = 1'b0;
        divdone  = 1'b0;
        divbusy  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: detects the hazards forwarding cannot cover in the
// 5-stage MIPS core (load-use, branch compare in D, divide occupancy in E)
// and drives the stall/flush controls for F/D/E/M.
// Optional build macro HAZARD_PERF_CNT_EN adds a 32-bit stall-cycle counter
// on port stall_cnt; without it the port and counter do not exist.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrD,
  input  logic        branchD,
  input  logic [4:0]  WAE,
  input  logic        wregE,
  input  logic        memtoregE,
  input  logic [4:0]  WAM,
  input  logic        memtoregM,
  input  logic        divstartE,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushE,
  output logic        flushM,
  output logic        divbusy,
  output logic        divdoneE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic [4:0] rs;
  logic [4:0] rt;
  logic       lwstall;
  logic       brstall;
  logic       br_e_hit;
  logic       br_m_hit;
  logic       divstall;
  logic       unused_instr_bits;

  assign rs = instrD[25:21];
  assign rt = instrD[20:16];

  // Opcode/immediate fields play no part in hazard detection.
  assign unused_instr_bits = ^{instrD[31:26], instrD[15:0]};

  div_busy_fsm #(
    .DIV_LAT (DIV_LAT)
  ) u_div_fsm (
    .clk      (clk),
    .rst      (rst),
    .divstart (divstartE),
    .divstall (divstall),
    .divdone  (divdoneE),
    .divbusy  (divbusy)
  );

  // Dependence compares. A branch compares in D, so any pending write in E
  // stalls it, but in M only a load does (ALU results forward M->D).
  always_comb begin
    lwstall  = 1'b0;
    br_e_hit = 1'b0;
    br_m_hit = 1'b0;
    brstall  = 1'b0;
    lwstall  = memtoregE & wregE & (reg_hit(WAE, rs) | reg_hit(WAE, rt));
    br_e_hit = wregE & (reg_hit(WAE, rs) | reg_hit(WAE, rt));
    br_m_hit = memtoregM & (reg_hit(WAM, rs) | reg_hit(WAM, rt));
    if (branchD) begin
      brstall = br_e_hit | br_m_hit;
    end else begin
      brstall = 1'b0;
    end
  end

  // Control muxing. A divide holds E and bubbles M; a D hazard during a
  // divide is absorbed because D is already held, and E must not be
  // flushed while it is being held.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    stallF = lwstall | brstall | divstall;
    stallD = lwstall | brstall | divstall;
    stallE = divstall;
    flushM = divstall;
    if (divstall) begin
      flushE = 1'b0;
    end else begin
      flushE = lwstall | brstall;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Counts every edge at which D is held; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (stallD) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed test of hazard_stall_unit with DIV_LAT = 4.
// A behavioural model tracks the divide as "cycles since start" and derives
// every output from the hazard rules; a negedge process compares all outputs
// each cycle, and directed steps pin a few hand-computed values.
module tb_hazard_stall_unit;

  localparam int DL = 4;

  logic        clk;
  logic        rst;
  logic [31:0] instrD;
  logic        branchD;
  logic [4:0]  WAE;
  logic        wregE;
  logic        memtoregE;
  logic [4:0]  WAM;
  logic        memtoregM;
  logic        divstartE;
  logic        stallF;
  logic        stallD;
  logic        stallE;
  logic        flushE;
  logic        flushM;
  logic        divbusy;
  logic        divdoneE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] m_cnt;
`endif

  int total;
  int bad;
  int m_k;        // cycles elapsed since the divide was accepted; 0 = idle
  logic check_en;

  hazard_stall_unit #(
    .DIV_LAT (DL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instrD    (instrD),
    .branchD   (branchD),
    .WAE       (WAE),
    .wregE     (wregE),
    .memtoregE (memtoregE),
    .WAM       (WAM),
    .memtoregM (memtoregM),
    .divstartE (divstartE),
    .stallF    (stallF),
    .stallD    (stallD),
    .stallE    (stallE),
    .flushE    (flushE),
    .flushM    (flushM),
    .divbusy   (divbusy),
    .divdoneE  (divdoneE)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rs, input int rt);
    logic [31:0] w;
    w = 32'd0;
    w[25:21] = rs[4:0];
    w[20:16] = rt[4:0];
    return w;
  endfunction

  // Model: hazard from D-stage register dependence (before divide absorption).
  function automatic logic m_dhaz();
    int rs;
    int rt;
    logic e_match;
    logic m_match;
    rs = int'(instrD[25:21]);
    rt = int'(instrD[20:16]);
    e_match = (WAE != 5'd0) && (int'(WAE) == rs || int'(WAE) == rt);
    m_match = (WAM != 5'd0) && (int'(WAM) == rs || int'(WAM) == rt);
    if (memtoregE && wregE && e_match) return 1'b1;
    if (branchD && wregE && e_match) return 1'b1;
    if (branchD && memtoregM && m_match) return 1'b1;
    return 1'b0;
  endfunction

  // Model: E held by a divide this cycle.
  function automatic logic m_div();
    if (m_k == 0) return divstartE;
    return (m_k < DL);
  endfunction

  // Model state advances at each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_k      <= 0;
      check_en <= 1'b1;
    end else if (m_k == 0) begin
      m_k <= divstartE ? 1 : 0;
    end else if (m_k < DL) begin
      m_k <= m_k + 1;
    end else begin
      m_k <= 0;
    end
`ifdef HAZARD_PERF_CNT_EN
    if (rst) m_cnt <= 32'd0;
    else if (m_dhaz() || m_div()) m_cnt <= m_cnt + 32'd1;
`endif
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("stallF", {31'd0, stallF}, {31'd0, m_dhaz() | m_div()});
      check("stallD", {31'd0, stallD}, {31'd0, m_dhaz() | m_div()});
      check("stallE", {31'd0, stallE}, {31'd0, m_div()});
      check("flushM", {31'd0, flushM}, {31'd0, m_div()});
      check("flushE", {31'd0, flushE}, {31'd0, m_dhaz() & ~m_div()});
      check("divbusy", {31'd0, divbusy}, {31'd0, m_k != 0});
      check("divdoneE", {31'd0, divdoneE}, {31'd0, m_k == DL});
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cnt", stall_cnt, m_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instrD    = 32'd0;
    branchD   = 1'b0;
    WAE       = 5'd0;
    wregE     = 1'b0;
    memtoregE = 1'b0;
    WAM       = 5'd0;
    memtoregM = 1'b0;
    divstartE = 1'b0;
  endtask

  // Hand-computed expectation on the four main controls, sampled mid-cycle.
  task automatic hand(input string name, input logic sd, input logic se, input logic fe, input logic bz);
    #2;
    check({name, ".stallD"}, {31'd0, stallD}, {31'd0, sd});
    check({name, ".stallE"}, {31'd0, stallE}, {31'd0, se});
    check({name, ".flushE"}, {31'd0, flushE}, {31'd0, fe});
    check({name, ".divbusy"}, {31'd0, divbusy}, {31'd0, bz});
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    m_k      = 0;
    check_en = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    m_cnt    = 32'd0;
`endif
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    hand("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.divdoneE", {31'd0, divdoneE}, 32'd0);

    // Load-use on rs: lw $8 in E, D reads $8.
    step();
    WAE = 5'd8; wregE = 1'b1; memtoregE = 1'b1; instrD = mk_instr(8, 0);
    hand("lw_rs", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    idle_inputs();
    hand("lw_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use on rt.
    step();
    WAE = 5'd5; wregE = 1'b1; memtoregE = 1'b1; instrD = mk_instr(3, 5);
    hand("lw_rt", 1'b1, 1'b0, 1'b1, 1'b0);

    // Branch on $9 with an ALU write in E: one stall, then M covers it.
    step();
    idle_inputs();
    branchD = 1'b1; instrD = mk_instr(9, 0); WAE = 5'd9; wregE = 1'b1;
    hand("br_alu_e", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    branchD = 1'b1; instrD = mk_instr(9, 0); WAE = 5'd0; wregE = 1'b0;
    WAM = 5'd9; memtoregM = 1'b0;
    hand("br_alu_m", 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch on $9 with a load: E match, then M match.
    step();
    idle_inputs();
    branchD = 1'b1; instrD = mk_instr(9, 0); WAE = 5'd9; wregE = 1'b1; memtoregE = 1'b1;
    hand("br_lw_e", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    WAE = 5'd0; wregE = 1'b0; memtoregE = 1'b0; WAM = 5'd9; memtoregM = 1'b1;
    hand("br_lw_m", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    idle_inputs();
    hand("br_lw_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Register zero never stalls.
    step();
    WAE = 5'd0; wregE = 1'b1; memtoregE = 1'b1; instrD = mk_instr(0, 0);
    hand("lw_zero", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle_inputs();
    branchD = 1'b1; WAM = 5'd0; memtoregM = 1'b1; instrD = mk_instr(0, 7);
    hand("br_zero", 1'b0, 1'b0, 1'b0, 1'b0);

    // Divide with divstartE held through DONE: 4 stall cycles, 1 done cycle.
    step();
    idle_inputs();
    divstartE = 1'b1;
    hand("div_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    step();
    step();
    hand("div_c4", 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    hand("div_c5", 1'b0, 1'b0, 1'b0, 1'b1);
    check("div_c5.divdoneE", {31'd0, divdoneE}, 32'd1);
    step();
    divstartE = 1'b0;
    hand("div_c6", 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle divstartE pulse still holds E for the full latency.
    step();
    divstartE = 1'b1;
    step();
    divstartE = 1'b0;
    step();
    hand("pulse_c3", 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    step();
    hand("pulse_c5", 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Divide overlapping a load-use: flushE suppressed, then reset on cycle 2.
    step();
    divstartE = 1'b1; WAE = 5'd8; wregE = 1'b1; memtoregE = 1'b1; instrD = mk_instr(8, 0);
    hand("div_lw_c1", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    hand("div_lw_c2", 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    idle_inputs();
    hand("div_rst_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use is re-evaluated once the divide is gone.
    step();
    WAE = 5'd8; wregE = 1'b1; memtoregE = 1'b1; instrD = mk_instr(8, 0);
    hand("lw_post_div", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    idle_inputs();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
